// File: rtl/dec_nto2n_seq.sv
// dec_nto2n_seq: registered N-to-2^N one-hot decoder with direct-select and auto-scan modes
module dec_nto2n_seq #(
  parameter int N = 3,
  localparam int OUT_W = 2**N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [N-1:0]     sel,
  input  logic [N-1:0]     last,
  output logic [OUT_W-1:0] D,
  output logic [N-1:0]     idx,
  output logic             valid,
  output logic             wrap
);
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state, state_n;
  logic [OUT_W-1:0] d_n;
  logic [N-1:0] idx_n;
  logic valid_n, wrap_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      D     <= '0;
      idx   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_n;
      D     <= d_n;
      idx   <= idx_n;
      valid <= valid_n;
      wrap  <= wrap_n;
    end
  end
  // idx only advances while strictly below last, so N-bit arithmetic never overflows
  always_comb begin
    state_n = state;
    d_n     = D;
    idx_n   = idx;
    valid_n = valid;
    wrap_n  = 1'b0;
    if (en) begin
      valid_n = 1'b1;
      if (!mode) begin
        state_n = DIRECT;
        idx_n   = sel;
        d_n     = OUT_W'(1) << sel;
      end else begin
        state_n = SCAN;
        idx_n   = (state == SCAN && idx < last) ? idx + 1'b1 : '0;
        d_n     = (state == SCAN && idx < last) ? D << 1 : OUT_W'(1);
        wrap_n  = state == SCAN && idx >= last;
      end
    end
  end
endmodule

// File: tb/tb_dec_nto2n_seq.sv
// tb_dec_nto2n_seq: directed vector table plus hand-written multi-cycle sequences for N=3
module tb_dec_nto2n_seq;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, mode = 1'b0;
  logic [2:0] sel = '0, last = '0;
  logic [7:0] D;
  logic [2:0] idx;
  logic valid, wrap;
  int n_chk = 0, n_fail = 0;

  dec_nto2n_seq #(.N(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .last(last),
    .D(D), .idx(idx), .valid(valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, e, m;
    logic [2:0] s, l;
    logic [7:0] d;
    logic [2:0] i;
    logic v, w;
  } vec_t;
  vec_t vq[$];

  function automatic vec_t mk(logic r, e, m, logic [2:0] s, l, logic [7:0] d, logic [2:0] i, logic v, w);
    vec_t x;
    x.r = r; x.e = e; x.m = m; x.s = s; x.l = l; x.d = d; x.i = i; x.v = v; x.w = w;
    return x;
  endfunction

  task automatic cyc(input logic r, e, m, input logic [2:0] s, l);
    rst = r; en = e; mode = m; sel = s; last = l;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] d, input logic [2:0] i, input logic v, w);
    n_chk++;
    if ({D, idx, valid, wrap} !== {d, i, v, w}) begin
      n_fail++;
      $display("FAIL %s: got D=%h idx=%0d valid=%b wrap=%b, want D=%h idx=%0d valid=%b wrap=%b",
               name, D, idx, valid, wrap, d, i, v, w);
    end
  endtask

  initial begin
    // reset, then direct sweep sel=0..7
    vq.push_back(mk(1, 1, 1, 3'd5, 3'd7, 8'h00, 3'd0, 0, 0));
    vq.push_back(mk(0, 1, 0, 3'd0, 3'd0, 8'h01, 3'd0, 1, 0));
    vq.push_back(mk(0, 1, 0, 3'd1, 3'd0, 8'h02, 3'd1, 1, 0));
    vq.push_back(mk(0, 1, 0, 3'd2, 3'd0, 8'h04, 3'd2, 1, 0));
    vq.push_back(mk(0, 1, 0, 3'd3, 3'd0, 8'h08, 3'd3, 1, 0));
    vq.push_back(mk(0, 1, 0, 3'd4, 3'd0, 8'h10, 3'd4, 1, 0));
    vq.push_back(mk(0, 1, 0, 3'd5, 3'd0, 8'h20, 3'd5, 1, 0));
    vq.push_back(mk(0, 1, 0, 3'd6, 3'd0, 8'h40, 3'd6, 1, 0));
    vq.push_back(mk(0, 1, 0, 3'd7, 3'd0, 8'h80, 3'd7, 1, 0));
    // full scan last=7: 0..7, 0 (wrap), 1
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd7, 8'h01, 3'd0, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd7, 8'h02, 3'd1, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd7, 8'h04, 3'd2, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd7, 8'h08, 3'd3, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd7, 8'h10, 3'd4, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd7, 8'h20, 3'd5, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd7, 8'h40, 3'd6, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd7, 8'h80, 3'd7, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd7, 8'h01, 3'd0, 1, 1));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd7, 8'h02, 3'd1, 1, 0));
    // reset, short scan last=2, then degenerate last=0, then freeze clears wrap
    vq.push_back(mk(1, 0, 0, 3'd0, 3'd0, 8'h00, 3'd0, 0, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd2, 8'h01, 3'd0, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd2, 8'h02, 3'd1, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd2, 8'h04, 3'd2, 1, 0));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd2, 8'h01, 3'd0, 1, 1));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd0, 8'h01, 3'd0, 1, 1));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd0, 8'h01, 3'd0, 1, 1));
    vq.push_back(mk(0, 1, 1, 3'd0, 3'd0, 8'h01, 3'd0, 1, 1));
    vq.push_back(mk(0, 0, 1, 3'd3, 3'd0, 8'h01, 3'd0, 1, 0));

    for (int k = 0; k < vq.size(); k++) begin
      cyc(vq[k].r, vq[k].e, vq[k].m, vq[k].s, vq[k].l);
      chk($sformatf("vec%0d", k), vq[k].d, vq[k].i, vq[k].v, vq[k].w);
    end

    // freeze mid-scan at idx=4 while sel/last wiggle
    cyc(1, 0, 0, 3'd0, 3'd0);
    for (int k = 0; k < 5; k++) cyc(0, 1, 1, 3'd0, 3'd7);
    chk("frz_pre", 8'h10, 3'd4, 1, 0);
    cyc(0, 0, 0, 3'd7, 3'd0); chk("frz0", 8'h10, 3'd4, 1, 0);
    cyc(0, 0, 1, 3'd2, 3'd1); chk("frz1", 8'h10, 3'd4, 1, 0);
    cyc(0, 0, 0, 3'd6, 3'd3); chk("frz2", 8'h10, 3'd4, 1, 0);
    cyc(0, 1, 1, 3'd0, 3'd7); chk("frz_resume", 8'h20, 3'd5, 1, 0);

    // limit cut below idx, then switch to direct
    cyc(0, 1, 1, 3'd0, 3'd3); chk("cut", 8'h01, 3'd0, 1, 1);
    cyc(0, 1, 0, 3'd6, 3'd3); chk("to_direct", 8'h40, 3'd6, 1, 0);

    // reset mid-scan at idx=6
    for (int k = 0; k < 7; k++) cyc(0, 1, 1, 3'd0, 3'd7);
    chk("rst_pre", 8'h40, 3'd6, 1, 0);
    cyc(1, 1, 1, 3'd0, 3'd7); chk("rst_mid", 8'h00, 3'd0, 0, 0);
    cyc(0, 1, 1, 3'd0, 3'd7); chk("rst_rel", 8'h01, 3'd0, 1, 0);
    cyc(0, 1, 1, 3'd0, 3'd7); chk("rst_next", 8'h02, 3'd1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
